// File: rtl/fp_fma_round_pipe_if.sv
// Format package and the request/response bundle between fp_fma and its rounding pipe.
// The issuing side uses the master modport; the rounding pipe uses the slave modport.
package fp_pkg;
  typedef enum logic [1:0] {FP32, FP64, FP16, BF16} fp_format_e;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} roundmode_e;

  function automatic int exp_bits(fp_format_e f);
    case (f)
      FP64:    return 11;
      FP16:    return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int man_bits(fp_format_e f);
    case (f)
      FP64:    return 52;
      FP16:    return 10;
      BF16:    return 7;
      default: return 23;
    endcase
  endfunction
endpackage

interface fp_fma_round_pipe_if #(
  parameter fp_pkg::fp_format_e FP_FORMAT = fp_pkg::FP32,
  parameter int TAG_WIDTH = 4
);
  localparam int EXP_WIDTH  = fp_pkg::exp_bits(FP_FORMAT);
  localparam int MANT_WIDTH = fp_pkg::man_bits(FP_FORMAT);
  localparam int FP_WIDTH   = 1 + EXP_WIDTH + MANT_WIDTH;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0] mant;
  } fp_t;

  typedef struct packed {
    fp_t        u_result;
    logic [1:0] rs;
    logic       round_en;
    logic       invalid;
    logic [1:0] exp_cout;
  } uround_res_t;

  logic                   valid_i;
  logic                   ready_o;
  uround_res_t            urnd_i;
  logic                   round_only_i;
  logic                   mul_ovf_i;
  logic                   mul_uf_i;
  logic                   mul_uround_out_i;
  fp_pkg::roundmode_e     rnd_i;
  logic [TAG_WIDTH-1:0]   tag_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [FP_WIDTH-1:0]    result_o;
  logic [4:0]             fflags_o;
  logic [TAG_WIDTH-1:0]   tag_o;

  modport master (
    output valid_i, urnd_i, round_only_i, mul_ovf_i, mul_uf_i, mul_uround_out_i, rnd_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, fflags_o, tag_o
  );

  modport slave (
    input  valid_i, urnd_i, round_only_i, mul_ovf_i, mul_uf_i, mul_uround_out_i, rnd_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, fflags_o, tag_o
  );
endinterface

// File: rtl/fp_fma_round_pipe.sv
// Two-stage rounding/flag pipe behind fp_fma: stage 1 decides the increment, stage 2 handles
// overflow/underflow and holds the output. Latency 2, one bundle per cycle, full back-pressure.
module fp_fma_round_pipe #(
  parameter fp_pkg::fp_format_e FP_FORMAT = fp_pkg::FP32,
  parameter int TAG_WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  fp_fma_round_pipe_if.slave       io
);
  import fp_pkg::*;

  localparam int EW = exp_bits(FP_FORMAT);
  localparam int MW = man_bits(FP_FORMAT);
  localparam int FW = 1 + EW + MW;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] mant;
  } fp_t;

  typedef struct packed {
    fp_t        u_result;
    logic [1:0] rs;
    logic       round_en;
    logic       invalid;
    logic [1:0] exp_cout;
  } uround_res_t;

  uround_res_t urnd;
  assign urnd = io.urnd_i;

  logic inc_raw, inc, inexact;

  always_comb begin
    inc_raw = 1'b0;
    case (io.rnd_i)
      RNE:     inc_raw = urnd.rs[1] & (urnd.rs[0] | urnd.u_result.mant[0]);
      RTZ:     inc_raw = 1'b0;
      RDN:     inc_raw = (|urnd.rs) & urnd.u_result.sign;
      RUP:     inc_raw = (|urnd.rs) & ~urnd.u_result.sign;
      RMM:     inc_raw = urnd.rs[1];
      default: inc_raw = 1'b0;
    endcase
    inc     = inc_raw & urnd.round_en;
    inexact = (|urnd.rs) & urnd.round_en;
  end

  logic                 s1_valid, s2_valid, accept, adv2;
  logic                 s1_sign, s1_exp_zero, s1_inc, s1_inexact, s1_round_en, s1_invalid;
  logic [EW+MW-1:0]     s1_sum;
  logic [1:0]           s1_exp_cout;
  logic                 s1_round_only, s1_mul_ovf, s1_mul_uf, s1_mul_uround;
  roundmode_e           s1_rnd;
  logic [TAG_WIDTH-1:0] s1_tag;

  // Stage 1 can take a new bundle whenever its current one is moving on (or it is empty).
  assign adv2       = ~s2_valid | io.ready_i;
  assign io.ready_o = ~s1_valid | adv2;
  assign accept     = io.valid_i & io.ready_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) s1_valid <= 1'b0;
    else if (io.ready_o)    s1_valid <= accept;
  end

  // Mantissa carry ripples into the exponent through the single wide add.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_sign       <= urnd.u_result.sign;
      s1_sum        <= {urnd.u_result.exp, urnd.u_result.mant} + {{(EW+MW-1){1'b0}}, inc};
      s1_exp_zero   <= (urnd.u_result.exp == '0);
      s1_inc        <= inc;
      s1_inexact    <= inexact;
      s1_round_en   <= urnd.round_en;
      s1_invalid    <= urnd.invalid;
      s1_exp_cout   <= urnd.exp_cout;
      s1_round_only <= io.round_only_i;
      s1_mul_ovf    <= io.mul_ovf_i;
      s1_mul_uf     <= io.mul_uf_i;
      s1_mul_uround <= io.mul_uround_out_i;
      s1_rnd        <= io.rnd_i;
      s1_tag        <= io.tag_i;
    end
  end

  logic          ovf, byp_ovf, to_inf, tiny, of, uf, nx;
  logic [FW-1:0] res_d;

  always_comb begin
    ovf     = s1_round_en & (s1_mul_ovf | (s1_exp_cout == 2'b01) | (&s1_sum[EW+MW-1:MW]));
    byp_ovf = ~s1_round_en & s1_mul_ovf;
    to_inf  = 1'b0;
    case (s1_rnd)
      RNE, RMM: to_inf = 1'b1;
      RUP:      to_inf = ~s1_sign;
      RDN:      to_inf = s1_sign;
      default:  to_inf = 1'b0;
    endcase
    res_d = {s1_sign, s1_sum};
    of    = 1'b0;
    nx    = s1_inexact;
    if (ovf || byp_ovf) begin
      of = 1'b1;
      nx = 1'b1;
      if (to_inf || byp_ovf) res_d = {s1_sign, {EW{1'b1}}, {MW{1'b0}}};
      else                   res_d = {s1_sign, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
    end
    tiny = s1_exp_zero & (~s1_inc | s1_mul_uround);
    uf   = s1_inexact & (tiny | (s1_mul_uf & s1_round_only & s1_inexact));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_valid    <= 1'b0;
      io.result_o <= '0;
      io.fflags_o <= '0;
      io.tag_o    <= '0;
    end else begin
      if (flush_i)   s2_valid <= 1'b0;
      else if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid && !flush_i) begin
        io.result_o <= res_d;
        io.fflags_o <= {s1_invalid, 1'b0, of, uf, nx};
        io.tag_o    <= s1_tag;
      end
    end
  end

  assign io.valid_o = s2_valid;
endmodule

// File: tb/tb_fp_fma_round_pipe.sv
// Directed-vector bench for fp_fma_round_pipe: driver pushes expected results into a queue,
// an independent monitor pops and compares on each output handshake.
module tb_fp_fma_round_pipe;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic reset, flush;
  always #5 clk = ~clk;

  fp_fma_round_pipe_if #(.FP_FORMAT(FP32), .TAG_WIDTH(4)) ifc ();

  fp_fma_round_pipe #(.FP_FORMAT(FP32), .TAG_WIDTH(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (flush),
    .io      (ifc)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [3:0]  tag;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares on output handshakes and checks outputs hold during stalls.
  logic        held = 1'b0;
  logic [31:0] h_res;
  logic [4:0]  h_fl;
  logic [3:0]  h_tag;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (ifc.valid_o) begin
      if (held) begin
        chk("stall_stable_result", ifc.result_o, h_res);
        chk("stall_stable_fflags", ifc.fflags_o, h_fl);
        chk("stall_stable_tag", ifc.tag_o, h_tag);
      end
      if (ifc.ready_i) begin
        held = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("tag_order_%0d", e.tag), ifc.tag_o, e.tag);
          chk($sformatf("result_tag%0d", e.tag), ifc.result_o, e.res);
          chk($sformatf("fflags_tag%0d", e.tag), ifc.fflags_o, e.fl);
          if (e.lat >= 0) chk($sformatf("latency_tag%0d", e.tag), cyc + 1 - e.acc, e.lat);
        end
      end else begin
        held  = 1'b1;
        h_res = ifc.result_o;
        h_fl  = ifc.fflags_o;
        h_tag = ifc.tag_o;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic drive(input logic [31:0] u, input logic [1:0] rs, input logic ren, input logic inv,
                       input logic [1:0] ec, input logic ro, input logic mo, input logic mu,
                       input logic muo, input roundmode_e rm, input logic [3:0] tg);
    ifc.urnd_i           = {u, rs, ren, inv, ec};
    ifc.round_only_i     = ro;
    ifc.mul_ovf_i        = mo;
    ifc.mul_uf_i         = mu;
    ifc.mul_uround_out_i = muo;
    ifc.rnd_i            = rm;
    ifc.tag_i            = tg;
  endtask

  task automatic send(input logic [31:0] u, input logic [1:0] rs, input logic ren, input logic inv,
                      input logic [1:0] ec, input logic ro, input logic mo, input logic mu,
                      input logic muo, input roundmode_e rm, input logic [3:0] tg,
                      input logic [31:0] er, input logic [4:0] ef, input int lat);
    exp_t e;
    int waited = 0;
    @(negedge clk);
    drive(u, rs, ren, inv, ec, ro, mo, mu, muo, rm, tg);
    ifc.valid_i = 1'b1;
    #1;
    while (!ifc.ready_o && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!ifc.ready_o) begin
      chk("send_timeout", 0, 1);
    end else begin
      e.res = er; e.fl = ef; e.tag = tg; e.acc = cyc + 1; e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    ifc.valid_i = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    #3;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int sent;
    reset = 1'b1;
    flush = 1'b0;
    ifc.valid_i = 1'b0;
    ifc.ready_i = 1'b1;
    drive(32'h0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_valid_o", ifc.valid_o, 0);
    chk("reset_ready_o", ifc.ready_o, 1);
    chk("reset_result_o", ifc.result_o, 0);
    chk("reset_fflags_o", ifc.fflags_o, 0);
    chk("reset_tag_o", ifc.tag_o, 0);

    // Back-to-back directed vectors, each expected exactly 2 cycles after acceptance.
    //    u_result      rs     ren   inv   ecout  ro    mo    mu    muo   rnd  tag    result        flags  lat
    send(32'h3FFFFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'd1,  32'h40000000, 5'h01, 2);
    // mul_ovf flagged: overflow path, rounding mode picks inf vs max finite
    send(32'h7F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, RNE, 4'd2,  32'h7F800000, 5'h05, 2);
    send(32'h7F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, RTZ, 4'd3,  32'h7F7FFFFF, 5'h05, 2);
    send(32'hFF7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, RUP, 4'd4,  32'hFF7FFFFF, 5'h05, 2);
    // no mul_ovf: truncation stays finite, while rounding up carries into an all-ones exponent
    send(32'h7F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RTZ, 4'd5,  32'h7F7FFFFF, 5'h01, 2);
    send(32'h7F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'd6,  32'h7F800000, 5'h05, 2);
    send(32'h7FC00000, 2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'd7,  32'h7FC00000, 5'h10, 2);
    send(32'h00000001, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, RUP, 4'd8,  32'h00000002, 5'h03, 2);
    send(32'h00000001, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, RTZ, 4'd9,  32'h00000001, 5'h03, 2);
    send(32'h00000001, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RUP, 4'd10, 32'h00000002, 5'h01, 2);
    send(32'h80000000, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, RNE, 4'd11, 32'hFF800000, 5'h05, 2);
    send(32'hBF800000, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RDN, 4'd12, 32'hBF800001, 5'h01, 2);
    send(32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RMM, 4'd13, 32'h3F800001, 5'h01, 2);
    send(32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'd14, 32'h3F800000, 5'h01, 2);
    send(32'h7F000000, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, RDN, 4'd15, 32'h7F7FFFFF, 5'h05, 2);
    send(32'h00800000, 2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, RNE, 4'd0,  32'h00800000, 5'h03, 2);
    drain();

    // Back-pressure: six bundles, downstream stalls on cycles 3..6.
    sent = 0;
    for (int c = 0; c < 30 && sent < 6; c++) begin
      @(negedge clk);
      ifc.ready_i = !(c >= 3 && c <= 6);
      drive(32'h3F800000 + sent, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, sent[3:0]);
      ifc.valid_i = 1'b1;
      #1;
      if (c >= 3 && c <= 6) chk($sformatf("bp_ready_low_c%0d", c), ifc.ready_o, 0);
      if (ifc.ready_o) begin
        e.res = 32'h3F800000 + sent; e.fl = 5'h00; e.tag = sent[3:0]; e.acc = cyc + 1; e.lat = -1;
        q.push_back(e);
        sent++;
      end
      @(posedge clk);
      #1;
      ifc.valid_i = 1'b0;
    end
    chk("bp_all_sent", sent, 6);
    ifc.ready_i = 1'b1;
    drain();

    // Flush with two entries in flight while stalled; the flush-cycle bundle is dropped.
    ifc.ready_i = 1'b0;
    send(32'h40400000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'd1, 32'h40400000, 5'h00, -1);
    send(32'h40800000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'd2, 32'h40800000, 5'h00, -1);
    @(negedge clk);
    #1;
    chk("pre_flush_valid", ifc.valid_o, 1);
    flush = 1'b1;
    drive(32'h40A00000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'd9);
    ifc.valid_i = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    ifc.valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("flush_valid_o", ifc.valid_o, 0);
    chk("flush_ready_o", ifc.ready_o, 1);
    ifc.ready_i = 1'b1;
    send(32'h40C00000, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RTZ, 4'd3, 32'h40C00000, 5'h01, 2);
    drain();

    // Reset with two entries in flight while stalled.
    ifc.ready_i = 1'b0;
    send(32'h41000000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'd4, 32'h41000000, 5'h00, -1);
    send(32'h41100000, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'd5, 32'h41100000, 5'h00, -1);
    @(negedge clk);
    #1;
    chk("pre_reset_valid", ifc.valid_o, 1);
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_reset_valid_o", ifc.valid_o, 0);
    chk("mid_reset_result_o", ifc.result_o, 0);
    chk("mid_reset_tag_o", ifc.tag_o, 0);
    ifc.ready_i = 1'b1;
    send(32'h3FFFFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, RNE, 4'd6, 32'h40000000, 5'h01, 2);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_fma_round_pipe.md
Name: fp_fma_round_pipe

Overview:
- Pipelined rounding and flag-generation stage directly downstream of fp_fma; consumes its unrounded result bundle and side flags.
- Produces the final IEEE-754 result and fflags.
- Wraps the combinational FMA datapath with a valid/ready handshake, two register stages and full back-pressure.
- Carries an opaque tag so the issuing unit can match responses to requests.

Parameters:
- FP_FORMAT, FP32, fp_format_e selecting widths (FP_WIDTH, EXP_WIDTH, MANT_WIDTH via fp_pkg).
- TAG_WIDTH, 4, width of the pass-through request tag.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- flush_i  in  1  synchronous kill of all in-flight entries
- valid_i  in  1  upstream bundle valid
- ready_o  out  1  stage can accept a bundle this cycle
- urnd_i  in  uround_res_t(FP_FORMAT)  fp_fma urnd_result_o: u_result, rs, round_en, invalid, exp_cout
- round_only_i  in  1  fp_fma round_only
- mul_ovf_i  in  1  fp_fma mul_ovf
- mul_uf_i  in  1  fp_fma mul_uf
- mul_uround_out_i  in  1  fp_fma mul_uround_out (tininess-after-rounding hint)
- rnd_i  in  roundmode_e  rounding mode captured with the bundle
- tag_i  in  TAG_WIDTH  request tag
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- result_o  out  FP_WIDTH  rounded result
- fflags_o  out  5  {NV,DZ,OF,UF,NX}; DZ is always 0
- tag_o  out  TAG_WIDTH  tag of result_o

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. On reset, s1_valid, s2_valid and valid_o are 0; result_o, fflags_o and tag_o are 0.
- Handshake:
  - Accept when valid_i & ready_o.
  - ready_o = ~s1_valid | ~s2_valid | ready_i.
  - Advance the pipeline when stage 2 is empty or drains; stages hold while stalled.
  - Latency is 2 cycles with no stall; throughput is 1 bundle per cycle.
  - Outputs stay stable while valid_o & ~ready_i.
- Stage 1, increment decision:
  - Signals: lsb = u_result.mant[0], r = rs[1], s = rs[0].
  - RNE: r&(s|lsb). RTZ: 0. RDN: (r|s)&sign. RUP: (r|s)&~sign. RMM: r.
  - inexact = (r|s) & round_en.
  - Register {sign, exp, mant} + inc as an (EXP_WIDTH+MANT_WIDTH)-bit add so mantissa carry ripples into exp. Also register inc, inexact, the flags, rnd and tag.
  - round_en = 0: bypass with inc = 0 and inexact = 0; u_result passes unchanged (NaN, inf, zero, R_IND).
- Stage 2, overflow:
  - Overflow when round_en & (mul_ovf | exp_cout == 2'b01 | rounded exp == all-ones).
  - On overflow, OF = NX = 1.
  - Result is inf for RNE/RMM, for RUP when positive, and for RDN when negative; otherwise max finite (exp all-ones minus 1, mant all-ones), keeping the sign.
  - mul_ovf with round_en = 0 still gives {sign, INF} with OF and NX.
- Stage 2, underflow:
  - tiny = pre-round exp == 0 & (~inc | mul_uround_out).
  - UF = inexact & (tiny | (mul_uf & round_only & inexact)).
- NV = invalid, independent of the rounding path.
- flush_i clears s1_valid and s2_valid the same cycle. Bundles accepted in the flush cycle are dropped. flush_i takes priority over acceptance.
- Reset or flush mid-stall: valid_o falls next cycle, and no stale result reappears.
- Simultaneous output drain and input accept: both stages shift, with no bubble.

Test Plan:
- FP32, RNE, u_result = 0x3FFFFFFF, rs = 2'b11, round_en = 1 -> result_o = 0x40000000, fflags = 0x01, 2 cycles after accept.
- u_result = 0x7F7FFFFF, rs = 2'b10, RNE -> 0x7F800000, fflags = 0x05; same input with RTZ -> 0x7F7FFFFF, fflags = 0x05; sign = 1 with RUP -> 0xFF7FFFFF.
- round_en = 0, invalid = 1, u_result = 0x7FC00000, any rs -> 0x7FC00000, fflags = 0x10, no NX.
- Subnormal: u_result = 0x00000001, rs = 2'b01, RUP -> 0x00000002, fflags = 0x03; RTZ -> 0x00000001, fflags = 0x03.
- Back-pressure: stream 6 bundles with ready_i low for cycles 3-6 -> ready_o low after 2 bundles are held, outputs stable, all 6 tags exit in order with none lost or duplicated.
- flush_i and reset_i asserted with 2 entries in flight and ready_i = 0 -> valid_o = 0 next cycle; the next accepted bundle appears after exactly 2 cycles.
